// File: rtl/dac_sched_pkg.sv
// Shared types and sizing helpers for the DAC frame scheduler.
// Imported by the interface, the serial shifter and the top level.
package dac_sched_pkg;

  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    if (max_val <= 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dac_frame_scheduler_if.sv
// Bundle between the sample producers and the scheduler, including the DAC pins.
// The master side drives requests and data; the slave side is the scheduler.
interface dac_frame_scheduler_if
  import dac_sched_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = DATA_W_DEF
);
  logic                   en;
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] data;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   sck;
  logic                   si;
  logic                   not_ld;
  logic [DATA_W-1:0]      pdata_mon;

  modport master (
    output en, req, data,
    input  grant, busy, sck, si, not_ld, pdata_mon
  );

  modport slave (
    input  en, req, data,
    output grant, busy, sck, si, not_ld, pdata_mon
  );
endinterface

// File: rtl/dac_serial_shifter.sv
// Shifts one DAC word out MSB first with a divided serial clock.
// o_done is high on the edge that ends the last bit's high half.
module dac_serial_shifter
  import dac_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SCK_DIV = 4
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_sck,
  output logic              o_si,
  output logic              o_done
);
  localparam int BIT_W = cnt_w(DATA_W);
  localparam int PH_W  = cnt_w(SCK_DIV);

  logic [DATA_W-1:0] r_shreg;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [PH_W-1:0]   r_phase;
  logic              r_active;
  logic              r_sck;
  logic              r_si;
  logic              w_half_end;
  logic              w_last;

  assign w_half_end = r_active && (r_phase == PH_W'(SCK_DIV - 1));
  assign w_last     = w_half_end && r_sck && (r_bit_cnt == BIT_W'(DATA_W - 1));

  // si is only updated when sck falls, so it is stable across every rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_phase   <= '0;
      r_active  <= 1'b0;
      r_sck     <= 1'b0;
      r_si      <= 1'b0;
    end else if (i_load) begin
      r_shreg   <= {i_data[DATA_W-2:0], 1'b0};
      r_si      <= i_data[DATA_W-1];
      r_sck     <= 1'b0;
      r_phase   <= '0;
      r_bit_cnt <= '0;
      r_active  <= 1'b1;
    end else if (r_active) begin
      if (w_half_end) begin
        r_phase <= '0;
        if (!r_sck) begin
          r_sck <= 1'b1;
        end else if (w_last) begin
          r_sck    <= 1'b0;
          r_si     <= 1'b0;
          r_active <= 1'b0;
        end else begin
          r_sck     <= 1'b0;
          r_si      <= r_shreg[DATA_W-1];
          r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

  assign o_sck  = r_sck;
  assign o_si   = r_si;
  assign o_done = w_last;

endmodule

// File: rtl/dac_frame_scheduler.sv
// Round-robin scheduler sharing one serial DAC link between NREQ producers.
// Grants a requester, shifts its word out, then strobes not_ld to load the DAC.
module dac_frame_scheduler
  import dac_sched_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SCK_DIV   = 4,
  parameter int LD_CYCLES = 2
)(
  input  logic                  clk,
  input  logic                  rst_n,
  dac_frame_scheduler_if.slave  bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LD_W  = cnt_w(LD_CYCLES);

  state_t            r_state, w_state_next;
  logic [PTR_W-1:0]  r_rr, w_rr_next;
  logic [NREQ-1:0]   r_grant, w_grant_next;
  logic              r_busy, w_busy_next;
  logic              r_not_ld, w_not_ld_next;
  logic [LD_W-1:0]   r_ld_cnt, w_ld_cnt_next;
  logic [DATA_W-1:0] r_pdata, w_pdata_next;

  logic              w_found;
  logic [PTR_W-1:0]  w_win;
  logic [PTR_W:0]    w_idx;
  logic [DATA_W-1:0] w_win_data;
  logic              w_start;
  logic              w_shift_done;

  // First set request at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_rr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NREQ)) w_idx = w_idx - (PTR_W+1)'(NREQ);
      if (!w_found && bus.req[w_idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PTR_W-1:0];
      end
    end
  end

  assign w_win_data = bus.data[int'(w_win)*DATA_W +: DATA_W];

  always_comb begin
    w_state_next  = r_state;
    w_rr_next     = r_rr;
    w_grant_next  = '0;
    w_busy_next   = r_busy;
    w_not_ld_next = r_not_ld;
    w_ld_cnt_next = r_ld_cnt;
    w_pdata_next  = r_pdata;
    w_start       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.en && w_found) begin
          w_start      = 1'b1;
          w_grant_next = NREQ'(1'b1) << w_win;
          w_busy_next  = 1'b1;
          w_pdata_next = w_win_data;
          w_rr_next    = (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_shift_done) begin
          w_not_ld_next = 1'b0;
          w_ld_cnt_next = '0;
          w_state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (r_ld_cnt == LD_W'(LD_CYCLES - 1)) begin
          w_not_ld_next = 1'b1;
          w_busy_next   = 1'b0;
          w_state_next  = ST_IDLE;
        end else begin
          w_ld_cnt_next = r_ld_cnt + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rr     <= '0;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_not_ld <= 1'b1;
      r_ld_cnt <= '0;
      r_pdata  <= '0;
    end else begin
      r_state  <= w_state_next;
      r_rr     <= w_rr_next;
      r_grant  <= w_grant_next;
      r_busy   <= w_busy_next;
      r_not_ld <= w_not_ld_next;
      r_ld_cnt <= w_ld_cnt_next;
      r_pdata  <= w_pdata_next;
    end
  end

  dac_serial_shifter #(
    .DATA_W  (DATA_W),
    .SCK_DIV (SCK_DIV)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_start),
    .i_data (w_win_data),
    .o_sck  (bus.sck),
    .o_si   (bus.si),
    .o_done (w_shift_done)
  );

  assign bus.grant     = r_grant;
  assign bus.busy      = r_busy;
  assign bus.not_ld    = r_not_ld;
  assign bus.pdata_mon = r_pdata;

endmodule
